// File: rtl/bus_dma_pkg.sv
// rtl/bus_dma_pkg.sv - register map, control/status bit positions and FSM states for bus_dma_host
package bus_dma_pkg;

    localparam logic [2:0] REG_SRC    = 3'd0;
    localparam logic [2:0] REG_DST    = 3'd1;
    localparam logic [2:0] REG_LEN    = 3'd2;
    localparam logic [2:0] REG_CTRL   = 3'd3;
    localparam logic [2:0] REG_STATUS = 3'd4;

    localparam int CTRL_START  = 0;
    localparam int CTRL_IRQ_EN = 1;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_ERR  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_WR_REQ,
        ST_WR_WAIT,
        ST_DONE,
        ST_ERROR
    } dma_state_e;

endpackage

// File: rtl/bus_dma_regs.sv
// rtl/bus_dma_regs.sv - device-port register file for bus_dma_host (irq output with BUS_DMA_IRQ_EN)
module bus_dma_regs
    import bus_dma_pkg::*;
#(
    parameter int DataWidth    = 32,
    parameter int AddressWidth = 32,
    parameter int LenWidth     = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    dev_req_i,
    input  logic                    dev_we_i,
    input  logic [3:0]              dev_be_i,
    input  logic [AddressWidth-1:0] dev_addr_i,
    input  logic [DataWidth-1:0]    dev_wdata_i,
    output logic                    dev_rvalid_o,
    output logic [DataWidth-1:0]    dev_rdata_o,
    output logic                    dev_err_o,
    input  logic                    busy,
    input  logic                    set_done,
    input  logic                    set_err,
    output logic [AddressWidth-1:0] src,
    output logic [AddressWidth-1:0] dst,
    output logic [LenWidth-1:0]     len,
    output logic                    start
`ifdef BUS_DMA_IRQ_EN
    ,
    output logic                    irq
`endif
);

    logic [2:0]           offset;
    logic                 wr_ok;
    logic                 bad_off;
    logic                 done_q;
    logic                 err_q;
    logic                 irq_en_rd;
    logic [DataWidth-1:0] rd_mux;
    logic                 unused_addr;

    assign offset      = dev_addr_i[4:2];
    assign unused_addr = ^{dev_addr_i[AddressWidth-1:5], dev_addr_i[1:0]};
    assign wr_ok       = dev_req_i && dev_we_i && (dev_be_i == 4'hF);
    assign bad_off     = (offset > REG_STATUS);
    assign start       = wr_ok && (offset == REG_CTRL) && dev_wdata_i[CTRL_START] && !busy;

`ifdef BUS_DMA_IRQ_EN
    logic irq_en_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            irq_en_q <= 1'b0;
        end else if (wr_ok && (offset == REG_CTRL)) begin
            irq_en_q <= dev_wdata_i[CTRL_IRQ_EN];
        end
    end

    assign irq_en_rd = irq_en_q;
    assign irq       = irq_en_q && (done_q || err_q);
`else
    assign irq_en_rd = 1'b0;
`endif

    always_comb begin
        rd_mux = '0;
        case (offset)
            REG_SRC:    rd_mux = DataWidth'(src);
            REG_DST:    rd_mux = DataWidth'(dst);
            REG_LEN:    rd_mux = DataWidth'(len);
            REG_CTRL:   rd_mux[CTRL_IRQ_EN] = irq_en_rd;
            REG_STATUS: begin
                rd_mux[STAT_BUSY] = busy;
                rd_mux[STAT_DONE] = done_q;
                rd_mux[STAT_ERR]  = err_q;
            end
            default:    rd_mux = '0;
        endcase
    end

    // Hardware set of DONE/ERR wins over a software clear in the same cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            src          <= '0;
            dst          <= '0;
            len          <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            dev_rvalid_o <= 1'b0;
            dev_rdata_o  <= '0;
            dev_err_o    <= 1'b0;
        end else begin
            if (wr_ok && !busy) begin
                case (offset)
                    REG_SRC: src <= {dev_wdata_i[AddressWidth-1:2], 2'b00};
                    REG_DST: dst <= {dev_wdata_i[AddressWidth-1:2], 2'b00};
                    REG_LEN: len <= dev_wdata_i[LenWidth-1:0];
                    default: ;
                endcase
            end
            done_q <= set_done ||
                      (done_q && !(wr_ok && (offset == REG_STATUS) && dev_wdata_i[STAT_DONE]));
            err_q  <= set_err ||
                      (err_q && !(wr_ok && (offset == REG_STATUS) && dev_wdata_i[STAT_ERR]));
            dev_rvalid_o <= dev_req_i;
            dev_err_o    <= dev_req_i && bad_off;
            dev_rdata_o  <= (dev_req_i && !dev_we_i) ? rd_mux : '0;
        end
    end

endmodule

// File: rtl/bus_dma_host.sv
// rtl/bus_dma_host.sv - word-copy DMA engine with device register port and host bus port (dma_irq_o with BUS_DMA_IRQ_EN)
module bus_dma_host
    import bus_dma_pkg::*;
#(
    parameter int DataWidth    = 32,
    parameter int AddressWidth = 32,
    parameter int LenWidth     = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    dev_req_i,
    input  logic                    dev_we_i,
    input  logic [3:0]              dev_be_i,
    input  logic [AddressWidth-1:0] dev_addr_i,
    input  logic [DataWidth-1:0]    dev_wdata_i,
    output logic                    dev_rvalid_o,
    output logic [DataWidth-1:0]    dev_rdata_o,
    output logic                    dev_err_o,
    output logic                    host_req_o,
    input  logic                    host_gnt_i,
    output logic [AddressWidth-1:0] host_addr_o,
    output logic                    host_we_o,
    output logic [3:0]              host_be_o,
    output logic [DataWidth-1:0]    host_wdata_o,
    input  logic                    host_rvalid_i,
    input  logic [DataWidth-1:0]    host_rdata_i,
    input  logic                    host_err_i
`ifdef BUS_DMA_IRQ_EN
    ,
    output logic                    dma_irq_o
`endif
);

    localparam logic [AddressWidth-1:0] WORD_STEP = {{(AddressWidth-3){1'b0}}, 3'd4};
    localparam logic [LenWidth-1:0]     ONE_WORD  = {{(LenWidth-1){1'b0}}, 1'b1};

    dma_state_e state, state_n;

    logic [AddressWidth-1:0] src, dst, cur_src, cur_dst;
    logic [LenWidth-1:0]     len, cnt;
    logic [DataWidth-1:0]    data_q;
    logic                    start, busy, set_done, set_err;

    assign busy = (state != ST_IDLE);

    bus_dma_regs #(
        .DataWidth    (DataWidth),
        .AddressWidth (AddressWidth),
        .LenWidth     (LenWidth)
    ) u_regs (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .dev_req_i    (dev_req_i),
        .dev_we_i     (dev_we_i),
        .dev_be_i     (dev_be_i),
        .dev_addr_i   (dev_addr_i),
        .dev_wdata_i  (dev_wdata_i),
        .dev_rvalid_o (dev_rvalid_o),
        .dev_rdata_o  (dev_rdata_o),
        .dev_err_o    (dev_err_o),
        .busy         (busy),
        .set_done     (set_done),
        .set_err      (set_err),
        .src          (src),
        .dst          (dst),
        .len          (len),
        .start        (start)
`ifdef BUS_DMA_IRQ_EN
        ,
        .irq          (dma_irq_o)
`endif
    );

    // Responses are only accepted in the WAIT states, so a stray rvalid after reset is ignored.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= ST_IDLE;
            cur_src <= '0;
            cur_dst <= '0;
            cnt     <= '0;
            data_q  <= '0;
        end else begin
            state <= state_n;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        cur_src <= src;
                        cur_dst <= dst;
                        cnt     <= len;
                    end
                end
                ST_RD_WAIT: begin
                    if (host_rvalid_i && !host_err_i) data_q <= host_rdata_i;
                end
                ST_WR_WAIT: begin
                    if (host_rvalid_i && !host_err_i) begin
                        cnt     <= cnt - ONE_WORD;
                        cur_src <= cur_src + WORD_STEP;
                        cur_dst <= cur_dst + WORD_STEP;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_n      = state;
        host_req_o   = 1'b0;
        host_we_o    = 1'b0;
        host_be_o    = 4'h0;
        host_addr_o  = '0;
        host_wdata_o = '0;
        set_done     = 1'b0;
        set_err      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_n = (len == '0) ? ST_DONE : ST_RD_REQ;
            end
            ST_RD_REQ: begin
                host_req_o  = 1'b1;
                host_be_o   = 4'hF;
                host_addr_o = cur_src;
                if (host_gnt_i) state_n = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (host_rvalid_i) state_n = host_err_i ? ST_ERROR : ST_WR_REQ;
            end
            ST_WR_REQ: begin
                host_req_o   = 1'b1;
                host_we_o    = 1'b1;
                host_be_o    = 4'hF;
                host_addr_o  = cur_dst;
                host_wdata_o = data_q;
                if (host_gnt_i) state_n = ST_WR_WAIT;
            end
            ST_WR_WAIT: begin
                if (host_rvalid_i) begin
                    if (host_err_i)            state_n = ST_ERROR;
                    else if (cnt == ONE_WORD)  state_n = ST_DONE;
                    else                       state_n = ST_RD_REQ;
                end
            end
            ST_DONE: begin
                set_done = 1'b1;
                state_n  = ST_IDLE;
            end
            ST_ERROR: begin
                set_err = 1'b1;
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

endmodule
